// File: rtl/branch_target_predictor_if.sv
// Lookup, resolve/update and flush signals between the IF/ID stages and the branch target predictor.
// The master side (pipeline) drives lookup PC and resolved outcomes; the slave side (predictor) returns predictions.
interface branch_target_predictor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  lookup_pc_i;
    logic             pred_taken_o;
    logic [XLEN-1:0]  pred_target_o;
    logic             upd_valid_i;
    logic [XLEN-1:0]  upd_pc_i;
    logic             upd_is_jump_i;
    logic             upd_taken_i;
    logic [XLEN-1:0]  upd_target_i;
    logic             upd_mispredict_i;
    logic             flush_all_i;
    logic [CNT_W-1:0] mispred_cnt_o;

    modport master (
        output lookup_pc_i, upd_valid_i, upd_pc_i, upd_is_jump_i, upd_taken_i,
               upd_target_i, upd_mispredict_i, flush_all_i,
        input  pred_taken_o, pred_target_o, mispred_cnt_o
    );

    modport slave (
        input  lookup_pc_i, upd_valid_i, upd_pc_i, upd_is_jump_i, upd_taken_i,
               upd_target_i, upd_mispredict_i, flush_all_i,
        output pred_taken_o, pred_target_o, mispred_cnt_o
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with saturating direction counters and a saturating misprediction counter.
// Lookup is combinational off registered state (zero latency); updates land on the next posedge, no backpressure.
module branch_target_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic clk,
    input  logic rst_n,
    branch_target_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_ONES = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = ~(CTR_ONES >> 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             r_valid [ENTRIES];
    logic [TAG_W-1:0] r_tag   [ENTRIES];
    logic [XLEN-1:0]  r_tgt   [ENTRIES];
    logic [CTR_W-1:0] r_ctr   [ENTRIES];
    logic [CNT_W-1:0] r_cnt;

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic [CTR_W-1:0] w_ctr_cur;
    logic [CTR_W-1:0] w_ctr_inc;
    logic [CTR_W-1:0] w_ctr_dec;
    logic             w_unused;

    assign w_lk_idx = bus.lookup_pc_i[IDX_W+1:2];
    assign w_lk_tag = bus.lookup_pc_i[XLEN-1:IDX_W+2];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    // Only a predicted-taken lookup redirects; otherwise fall through to the sequential PC.
    assign bus.pred_taken_o  = w_lk_hit & r_ctr[w_lk_idx][CTR_W-1];
    assign bus.pred_target_o = bus.pred_taken_o ? r_tgt[w_lk_idx]
                                                : bus.lookup_pc_i + XLEN'(4);
    assign bus.mispred_cnt_o = r_cnt;

    assign w_up_idx  = bus.upd_pc_i[IDX_W+1:2];
    assign w_up_tag  = bus.upd_pc_i[XLEN-1:IDX_W+2];
    assign w_up_hit  = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_ctr_cur = r_ctr[w_up_idx];
    assign w_ctr_inc = (w_ctr_cur == CTR_ONES) ? w_ctr_cur : w_ctr_cur + CTR_W'(1);
    assign w_ctr_dec = (w_ctr_cur == '0)       ? w_ctr_cur : w_ctr_cur - CTR_W'(1);
    assign w_unused  = &{1'b0, bus.upd_pc_i[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_tgt[i]   <= '0;
                r_ctr[i]   <= '0;
            end
        end else if (bus.flush_all_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (bus.upd_valid_i) begin
            if (w_up_hit) begin
                if (bus.upd_is_jump_i) begin
                    r_ctr[w_up_idx] <= CTR_ONES;
                    r_tgt[w_up_idx] <= bus.upd_target_i;
                end else if (bus.upd_taken_i) begin
                    r_ctr[w_up_idx] <= w_ctr_inc;
                    r_tgt[w_up_idx] <= bus.upd_target_i;
                end else begin
                    r_ctr[w_up_idx] <= w_ctr_dec;
                end
            end else if (bus.upd_taken_i) begin
                // Miss on a taken transfer replaces whatever aliased into this slot.
                r_valid[w_up_idx] <= 1'b1;
                r_tag[w_up_idx]   <= w_up_tag;
                r_tgt[w_up_idx]   <= bus.upd_target_i;
                r_ctr[w_up_idx]   <= bus.upd_is_jump_i ? CTR_ONES : CTR_WEAK;
            end
        end
    end

    // Counts even when a flush drops the accompanying update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (bus.upd_valid_i && bus.upd_mispredict_i && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed test of branch_target_predictor: allocation, counter saturation, aliasing, flush, reset, miss counter.
module tb_branch_target_predictor;
    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int CTR_W   = 2;
    localparam int CNT_W   = 2;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    branch_target_predictor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    branch_target_predictor #(
        .XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_W(CTR_W), .CNT_W(CNT_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic jmp, input logic tkn,
                       input logic [31:0] tgt, input logic mis);
        bus.upd_valid_i      = 1'b1;
        bus.upd_pc_i         = pc;
        bus.upd_is_jump_i    = jmp;
        bus.upd_taken_i      = tkn;
        bus.upd_target_i     = tgt;
        bus.upd_mispredict_i = mis;
        step();
        bus.upd_valid_i      = 1'b0;
        bus.upd_mispredict_i = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_tkn,
                        input logic [31:0] exp_tgt);
        bus.lookup_pc_i = pc;
        #1;
        check_eq({tag, ".taken"}, {31'd0, bus.pred_taken_o}, {31'd0, exp_tkn});
        check_eq({tag, ".target"}, bus.pred_target_o, exp_tgt);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        bus.lookup_pc_i      = 32'h100;
        bus.upd_valid_i      = 1'b0;
        bus.upd_pc_i         = '0;
        bus.upd_is_jump_i    = 1'b0;
        bus.upd_taken_i      = 1'b0;
        bus.upd_target_i     = '0;
        bus.upd_mispredict_i = 1'b0;
        bus.flush_all_i      = 1'b0;
        #12;
        look("in_reset", 32'h100, 1'b0, 32'h104);
        rst_n = 1'b1;
        step();

        look("t1", 32'h100, 1'b0, 32'h104);
        check_eq("t1.cnt", 32'(bus.mispred_cnt_o), 32'd0);
        look("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0);
        look("t2.alloc", 32'h40, 1'b1, 32'h80);

        upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        look("t3.ctr1", 32'h40, 1'b0, 32'h44);
        for (int i = 0; i < 3; i++) upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0);
        look("t3.sat0", 32'h40, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0);
        upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0);
        upd(32'h40, 1'b0, 1'b1, 32'h90, 1'b0);
        look("t3.ctr3", 32'h40, 1'b1, 32'h90);
        upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        look("t3.sat3_dec", 32'h40, 1'b1, 32'h90);
        upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        look("t3.ctr1b", 32'h40, 1'b0, 32'h44);

        upd(32'h40, 1'b0, 1'b1, 32'h80, 1'b0);
        look("t4.hit40", 32'h40, 1'b1, 32'h80);
        upd(32'h80, 1'b1, 1'b1, 32'h200, 1'b0);
        look("t4.alias40", 32'h40, 1'b0, 32'h44);
        look("t4.hit80", 32'h80, 1'b1, 32'h200);
        upd(32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
        look("t4.ctr2", 32'h80, 1'b1, 32'h200);
        upd(32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
        look("t4.ctr1", 32'h80, 1'b0, 32'h84);
        upd(32'h80, 1'b1, 1'b1, 32'h240, 1'b0);
        upd(32'h80, 1'b0, 1'b0, 32'h0, 1'b0);
        look("t4.jump_ones", 32'h80, 1'b1, 32'h240);

        upd(32'h60, 1'b0, 1'b0, 32'h500, 1'b0);
        look("nt_noalloc", 32'h60, 1'b0, 32'h64);
        upd(32'h60, 1'b0, 1'b1, 32'h520, 1'b0);
        look("weak_alloc", 32'h60, 1'b1, 32'h520);

        // Asynchronous reset with an update pending: nothing of it may land.
        bus.upd_valid_i      = 1'b1;
        bus.upd_pc_i         = 32'h4C;
        bus.upd_is_jump_i    = 1'b1;
        bus.upd_taken_i      = 1'b1;
        bus.upd_target_i     = 32'h600;
        bus.upd_mispredict_i = 1'b1;
        #2 rst_n = 1'b0;
        look("rst.async", 32'h80, 1'b0, 32'h84);
        step();
        bus.upd_valid_i      = 1'b0;
        bus.upd_mispredict_i = 1'b0;
        rst_n = 1'b1;
        step();
        look("rst.dropped", 32'h4C, 1'b0, 32'h50);
        check_eq("rst.cnt", 32'(bus.mispred_cnt_o), 32'd0);

        upd(32'h48, 1'b0, 1'b1, 32'h300, 1'b0);
        look("t5.pre", 32'h48, 1'b1, 32'h300);
        bus.flush_all_i = 1'b1;
        upd(32'h44, 1'b0, 1'b1, 32'h700, 1'b1);
        bus.flush_all_i = 1'b0;
        look("t5.flush48", 32'h48, 1'b0, 32'h4C);
        look("t5.flush44", 32'h44, 1'b0, 32'h48);
        check_eq("t5.cnt", 32'(bus.mispred_cnt_o), 32'd1);

        bus.lookup_pc_i      = 32'h48;
        bus.upd_valid_i      = 1'b1;
        bus.upd_pc_i         = 32'h48;
        bus.upd_is_jump_i    = 1'b0;
        bus.upd_taken_i      = 1'b1;
        bus.upd_target_i     = 32'h400;
        bus.upd_mispredict_i = 1'b1;
        #1;
        check_eq("t6.same.taken", {31'd0, bus.pred_taken_o}, 32'd0);
        check_eq("t6.same.target", bus.pred_target_o, 32'h4C);
        step();
        bus.upd_valid_i      = 1'b0;
        bus.upd_mispredict_i = 1'b0;
        look("t6.next", 32'h48, 1'b1, 32'h400);
        check_eq("t6.cnt2", 32'(bus.mispred_cnt_o), 32'd2);

        bus.upd_mispredict_i = 1'b1;
        step();
        bus.upd_mispredict_i = 1'b0;
        check_eq("t6.novalid", 32'(bus.mispred_cnt_o), 32'd2);
        upd(32'h48, 1'b0, 1'b1, 32'h400, 1'b1);
        check_eq("t6.cnt3", 32'(bus.mispred_cnt_o), 32'd3);
        upd(32'h48, 1'b0, 1'b1, 32'h400, 1'b1);
        upd(32'h48, 1'b0, 1'b1, 32'h400, 1'b1);
        check_eq("t6.cnt_sat", 32'(bus.mispred_cnt_o), 32'd3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
